// File: rtl/mult4u_share_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package  : mult4u_ctrl_pkg
// Brief    : Shared types and widths for the time-shared 4x4 multiplier
//            controller family.
// Revision : 1.0
// ============================================================================
package mult4u_ctrl_pkg;

  localparam int OP_W     = 4;   // multiplier operand width
  localparam int PROD_W   = 8;   // multiplier product width
  localparam int ID_W     = 3;   // requester index width (up to 8 requesters)
  localparam int ERRCNT_W = 8;   // saturating error counter width

  // Controller phases: arbitration, forward product, swapped product, response.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN_A = 2'd1,
    RUN_B = 2'd2,
    RESP  = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/mult4u_share_ctrl_if.sv
`default_nettype none
// ============================================================================
// Interface: mult4u_share_ctrl_if
// Brief    : Request bus, response bus and multiplier link of the shared
//            multiplier controller. The controller uses the slave modport;
//            requesters, consumer and multiplier together form the master.
// Revision : 1.0
// ============================================================================
interface mult4u_share_ctrl_if
  import mult4u_ctrl_pkg::*;
#(
  parameter int N = 4
) ();

  logic [N-1:0]        req_valid;
  logic [N-1:0]        req_ready;
  logic [OP_W*N-1:0]   req_a;
  logic [OP_W*N-1:0]   req_b;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [ID_W-1:0]     rsp_id;
  logic [PROD_W-1:0]   rsp_prod;
  logic                rsp_err;
  logic [OP_W-1:0]     mul_a;
  logic [OP_W-1:0]     mul_b;
  logic [PROD_W-1:0]   mul_p;

  modport master (
    output req_valid, req_a, req_b, rsp_ready, mul_p,
    input  req_ready, rsp_valid, rsp_id, rsp_prod, rsp_err, mul_a, mul_b
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready, mul_p,
    output req_ready, rsp_valid, rsp_id, rsp_prod, rsp_err, mul_a, mul_b
  );

endinterface
`default_nettype wire

// File: rtl/mult4u_share_ctrl_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin arbiter. The search starts one slot
//            after the previous winner and wraps; the first active request
//            wins. Produces a one-hot grant plus its encoded index.
// Revision : 1.0
// ============================================================================
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid
);

  // Rotating priority scan starting just after the previous winner.
  always_comb begin : p_pick
    int cand;
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand        = 0;
    for (int k = 1; k <= N; k++) begin
      cand = (int'(last_grant) + k) % N;
      if (!grant_valid && req[cand]) begin
        grant[cand] = 1'b1;
        grant_idx   = IDX_W'(cand);
        grant_valid = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mult4u_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mult4u_share_ctrl
// Brief    : Time-shares one combinational 4x4 unsigned multiplier between N
//            requesters. Every job runs A*B then B*A; differing products
//            trigger up to MAX_RETRY reruns before an error response.
// Revision : 1.0
// ============================================================================
module mult4u_share_ctrl
  import mult4u_ctrl_pkg::*;
#(
  parameter int N         = 4,
  parameter int SETTLE    = 2,
  parameter int MAX_RETRY = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  mult4u_share_ctrl_if.slave   bus,
  output logic [ERRCNT_W-1:0]  err_count
);

  localparam int               CNT_W       = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
  localparam logic [CNT_W-1:0] C_SETTLE    = CNT_W'(SETTLE);
  localparam logic [1:0]       C_MAX_RETRY = 2'(MAX_RETRY);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [1:0]            retry_q, retry_d;
  logic [OP_W-1:0]       a_q, a_d;
  logic [OP_W-1:0]       b_q, b_d;
  logic [ID_W-1:0]       id_q, id_d;
  logic [ID_W-1:0]       last_grant_q, last_grant_d;
  logic [PROD_W-1:0]     p1_q, p1_d;
  logic [OP_W-1:0]       mul_a_q, mul_a_d;
  logic [OP_W-1:0]       mul_b_q, mul_b_d;
  logic [PROD_W-1:0]     rsp_prod_q, rsp_prod_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [ERRCNT_W-1:0]   err_count_q, err_count_d;

  logic [N-1:0]          grant;
  logic [ID_W-1:0]       grant_idx;
  logic                  grant_valid;
  logic [OP_W-1:0]       sel_a;
  logic [OP_W-1:0]       sel_b;

  rr_arbiter #(
    .N     (N),
    .IDX_W (ID_W)
  ) u_arb (
    .req         (bus.req_valid),
    .last_grant  (last_grant_q),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  // Pick the winning requester's operand pair out of the packed buses.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) begin
        sel_a = bus.req_a[i*OP_W +: OP_W];
        sel_b = bus.req_b[i*OP_W +: OP_W];
      end
    end
  end

  // State and datapath registers; reset drops any job in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      retry_q      <= '0;
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= '0;
      last_grant_q <= ID_W'(N - 1);
      p1_q         <= '0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      rsp_prod_q   <= '0;
      rsp_err_q    <= 1'b0;
      err_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retry_q      <= retry_d;
      a_q          <= a_d;
      b_q          <= b_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
      p1_q         <= p1_d;
      mul_a_q      <= mul_a_d;
      mul_b_q      <= mul_b_d;
      rsp_prod_q   <= rsp_prod_d;
      rsp_err_q    <= rsp_err_d;
      err_count_q  <= err_count_d;
    end
  end

  // Next-state and datapath updates for the accept / A*B / B*A / respond loop.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    retry_d      = retry_q;
    a_d          = a_q;
    b_d          = b_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
    p1_d         = p1_q;
    mul_a_d      = mul_a_q;
    mul_b_d      = mul_b_q;
    rsp_prod_d   = rsp_prod_q;
    rsp_err_d    = rsp_err_q;
    err_count_d  = err_count_q;

    case (state_q)
      IDLE: begin
        // A grant always coincides with a valid request, so it is a transfer.
        if (grant_valid) begin
          a_d          = sel_a;
          b_d          = sel_b;
          id_d         = grant_idx;
          last_grant_d = grant_idx;
          retry_d      = '0;
          cnt_d        = C_SETTLE;
          mul_a_d      = sel_a;
          mul_b_d      = sel_b;
          state_d      = RUN_A;
        end
      end

      RUN_A: begin
        if (cnt_q == '0) begin
          p1_d    = bus.mul_p;
          mul_a_d = b_q;
          mul_b_d = a_q;
          cnt_d   = C_SETTLE;
          state_d = RUN_B;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      RUN_B: begin
        if (cnt_q == '0) begin
          if (bus.mul_p == p1_q) begin
            rsp_prod_d = p1_q;
            rsp_err_d  = 1'b0;
            state_d    = RESP;
          end else if (retry_q < C_MAX_RETRY) begin
            retry_d = retry_q + 1'b1;
            mul_a_d = a_q;
            mul_b_d = b_q;
            cnt_d   = C_SETTLE;
            state_d = RUN_A;
          end else begin
            // Out of retries: report the forward product flagged as suspect.
            rsp_prod_d  = p1_q;
            rsp_err_d   = 1'b1;
            err_count_d = (err_count_q == '1) ? err_count_q : err_count_q + 1'b1;
            state_d     = RESP;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      RESP: begin
        // Park the multiplier inputs at zero while idle to limit toggling.
        if (bus.rsp_ready) begin
          mul_a_d = '0;
          mul_b_d = '0;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs; no grant is offered while reset is asserted.
  always_comb begin
    bus.req_ready = '0;
    bus.rsp_valid = 1'b0;
    if (state_q == IDLE && !rst) begin
      bus.req_ready = grant;
    end
    if (state_q == RESP) begin
      bus.rsp_valid = 1'b1;
    end
  end

  assign bus.rsp_id   = id_q;
  assign bus.rsp_prod = rsp_prod_q;
  assign bus.rsp_err  = rsp_err_q;
  assign bus.mul_a    = mul_a_q;
  assign bus.mul_b    = mul_b_q;
  assign err_count    = err_count_q;

endmodule
`default_nettype wire

// File: tb/tb_mult4u_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult4u_share_ctrl
// Brief    : Self-checking bench for mult4u_share_ctrl with a faulty
//            multiplier model and a job-level reference model.
// Revision : 1.0
// ============================================================================
module tb_mult4u_share_ctrl;
  import mult4u_ctrl_pkg::*;

  localparam int N         = 4;
  localparam int SETTLE    = 2;
  localparam int MAX_RETRY = 1;
  localparam int PH        = SETTLE + 1;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [ERRCNT_W-1:0] err_count;

  mult4u_share_ctrl_if #(.N(N)) bus ();

  mult4u_share_ctrl #(
    .N         (N),
    .SETTLE    (SETTLE),
    .MAX_RETRY (MAX_RETRY)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  logic [N-1:0] vmask;
  logic [3:0]  op_a [N];
  logic [3:0]  op_b [N];
  bit          c15;
  bit          b3_arm;
  int          last_model;
  int          ec_model;

  // Multiplier with injectable faults: LSB flip when A==15, bit-3 flip for 6*5.
  always_comb begin
    bus.mul_p = {4'b0, bus.mul_a} * {4'b0, bus.mul_b};
    if (c15 && bus.mul_a == 4'd15) bus.mul_p = bus.mul_p ^ 8'h01;
    if (b3_arm && bus.mul_a == 4'd6 && bus.mul_b == 4'd5) bus.mul_p = bus.mul_p ^ 8'h08;
  end

  function automatic int rr_pick(input logic [N-1:0] m, input int last);
    int w;
    w = -1;
    for (int k = 1; k <= N; k++)
      if (w < 0 && m[(last + k) % N]) w = (last + k) % N;
    return w;
  endfunction

  // Job-level model: pass p computes A*B and B*A through the faulty multiplier.
  function automatic void ref_job(input int a, input int b, input bit f15, input bit fb3,
                                  output int prod, output bit err, output int passes);
    int pa, pb;
    bit done;
    done = 0; err = 1; prod = 0; passes = 0;
    for (int p = 0; p <= MAX_RETRY; p++) begin
      if (!done) begin
        pa = a * b;
        if (f15 && a == 15) pa = pa ^ 1;
        pb = b * a;
        if (f15 && b == 15) pb = pb ^ 1;
        if (fb3 && p == 0 && b == 6 && a == 5) pb = pb ^ 8;
        passes = p + 1;
        prod   = pa;
        if (pa == pb) begin
          err  = 0;
          done = 1;
        end
      end
    end
  endfunction

  task automatic apply();
    bus.req_valid = vmask;
    for (int i = 0; i < N; i++) begin
      bus.req_a[i*4 +: 4] = op_a[i];
      bus.req_b[i*4 +: 4] = op_b[i];
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    vmask = '0;
    bus.rsp_ready = 1'b0;
    apply();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    last_model = N - 1;
    ec_model   = 0;
  endtask

  // Serve one job end to end from the current IDLE cycle.
  task automatic serve(input bit f15, input bit fb3, input int stall,
                       input logic [N-1:0] raise, input string tag);
    int port, exp_port, lat, exp_prod, exp_pass, exp_lat, cyc, pos;
    bit exp_err, seen;
    logic [3:0] a, b, ea, eb;
    c15 = f15; b3_arm = fb3; seen = 0;
    bus.rsp_ready = (stall == 0);
    exp_port = rr_pick(vmask, last_model);
    cyc = 0;
    while (bus.req_ready == '0 && cyc < 50) begin
      @(negedge clk); #1; cyc++;
    end
    checks++;
    if (bus.req_ready == '0) begin
      failures++;
      $display("FAIL %s accept_timeout got req_ready=%b need grant of port %0d", tag, bus.req_ready, exp_port);
      c15 = 0; b3_arm = 0;
      return;
    end
    port = -1;
    for (int i = 0; i < N; i++) if (bus.req_ready[i]) port = i;
    checks++;
    if ($countones(bus.req_ready) != 1 || port != exp_port) begin
      failures++;
      $display("FAIL %s grant got req_ready=%b need port %0d", tag, bus.req_ready, exp_port);
    end
    a = op_a[exp_port]; b = op_b[exp_port];
    last_model = exp_port;
    ref_job(int'(a), int'(b), f15, fb3, exp_prod, exp_err, exp_pass);
    exp_lat = 2 * PH * exp_pass + 1;
    if (exp_err && ec_model < 255) ec_model++;

    @(posedge clk); #1;
    vmask[exp_port] = 1'b0;
    vmask = vmask | raise;
    apply();

    lat = 0;
    while (lat < exp_lat + 20) begin
      @(negedge clk); #1; lat++;
      if (bus.mul_a == 4'd6 && bus.mul_b == 4'd5) seen = 1;
      else if (seen) b3_arm = 0;
      if (bus.rsp_valid) break;
      if (lat < exp_lat) begin
        pos = (lat - 1) % (2 * PH);
        ea = (pos < PH) ? a : b;
        eb = (pos < PH) ? b : a;
        checks++;
        if (bus.mul_a !== ea || bus.mul_b !== eb) begin
          failures++;
          $display("FAIL %s mul_operands lat=%0d got %0d/%0d need %0d/%0d", tag, lat, bus.mul_a, bus.mul_b, ea, eb);
        end
      end
    end
    checks++;
    if (!bus.rsp_valid || lat != exp_lat) begin
      failures++;
      $display("FAIL %s latency got %0d (rsp_valid=%b) need %0d", tag, lat, bus.rsp_valid, exp_lat);
      c15 = 0; b3_arm = 0;
      return;
    end
    checks++;
    if (bus.rsp_prod !== 8'(exp_prod) || bus.rsp_id !== 3'(exp_port) ||
        bus.rsp_err !== exp_err || bus.req_ready !== '0) begin
      failures++;
      $display("FAIL %s response got prod=%0d id=%0d err=%b req_ready=%b need prod=%0d id=%0d err=%b req_ready=0",
               tag, bus.rsp_prod, bus.rsp_id, bus.rsp_err, bus.req_ready, exp_prod, exp_port, exp_err);
    end
    checks++;
    if (err_count !== 8'(ec_model)) begin
      failures++;
      $display("FAIL %s err_count got %0d need %0d", tag, err_count, ec_model);
    end
    for (int s = 0; s < stall; s++) begin
      @(negedge clk); #1;
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_prod !== 8'(exp_prod) || bus.rsp_id !== 3'(exp_port) ||
          bus.rsp_err !== exp_err || bus.req_ready !== '0) begin
        failures++;
        $display("FAIL %s stall_hold cycle=%0d got valid=%b prod=%0d id=%0d err=%b req_ready=%b need 1/%0d/%0d/%b/0",
                 tag, s, bus.rsp_valid, bus.rsp_prod, bus.rsp_id, bus.rsp_err, bus.req_ready,
                 exp_prod, exp_port, exp_err);
      end
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.mul_a !== 4'd0 || bus.mul_b !== 4'd0) begin
      failures++;
      $display("FAIL %s after_handshake got valid=%b mul=%0d/%0d need 0 0/0", tag, bus.rsp_valid, bus.mul_a, bus.mul_b);
    end
    c15 = 0; b3_arm = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.req_ready !== '0 || bus.rsp_valid !== 1'b0 || bus.rsp_id !== '0 || bus.rsp_prod !== '0 ||
        bus.rsp_err !== 1'b0 || bus.mul_a !== '0 || bus.mul_b !== '0 || err_count !== '0) begin
      failures++;
      $display("FAIL reset_state got rr=%b rv=%b id=%0d prod=%0d err=%b ma=%0d mb=%0d ec=%0d need all 0",
               bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_prod, bus.rsp_err, bus.mul_a, bus.mul_b, err_count);
    end
  endtask

  task automatic test_single();
    op_a[2] = 4'd13; op_b[2] = 4'd11;
    vmask = 4'b0100;
    apply();
    serve(0, 0, 0, '0, "single_13x11");
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < N; i++) begin
      op_a[i] = 4'(i + 1);
      op_b[i] = 4'd15;
    end
    vmask = '1;
    apply();
    for (int j = 0; j < N; j++) serve(0, 0, 0, '0, "round_robin");
  endtask

  task automatic test_retry_clean();
    op_a[0] = 4'd5; op_b[0] = 4'd6;
    vmask = 4'b0001;
    apply();
    serve(0, 1, 0, '0, "retry_clean");
  endtask

  task automatic test_retry_error();
    op_a[3] = 4'd15; op_b[3] = 4'd1;
    vmask = 4'b1000;
    apply();
    serve(1, 0, 0, '0, "retry_error");
  endtask

  task automatic test_resp_stall();
    op_a[0] = 4'd3; op_b[0] = 4'd7;
    op_a[1] = 4'd9; op_b[1] = 4'd2;
    vmask = 4'b0001;
    apply();
    serve(0, 0, 5, 4'b0010, "resp_stall");
    checks++;
    if (bus.req_ready !== 4'b0010) begin
      failures++;
      $display("FAIL stall_next_grant got req_ready=%b need 0010", bus.req_ready);
    end
    serve(0, 0, 0, '0, "stall_followup");
  endtask

  task automatic test_random();
    logic [N-1:0] nb;
    vmask = '0;
    for (int it = 0; it < 24; it++) begin
      nb = N'($urandom_range(0, 15)) & ~vmask;
      if ((vmask | nb) == '0) nb[it % N] = 1'b1;
      for (int i = 0; i < N; i++) begin
        if (nb[i]) begin
          op_a[i] = 4'($urandom);
          op_b[i] = 4'($urandom);
        end
      end
      vmask = vmask | nb;
      apply();
      serve($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
            int'($urandom_range(0, 2)), '0, "random");
    end
    vmask = '0;
    apply();
  endtask

  task automatic test_reset_midjob();
    int cyc;
    op_a[2] = 4'd9; op_b[2] = 4'd7;
    vmask = 4'b0100;
    bus.rsp_ready = 1'b1;
    apply();
    cyc = 0;
    while (bus.req_ready == '0 && cyc < 50) begin
      @(negedge clk); #1; cyc++;
    end
    @(posedge clk); #1;
    vmask = '0;
    apply();
    repeat (4) @(negedge clk);
    #1;
    checks++;
    if (bus.mul_a !== 4'd7 || bus.mul_b !== 4'd9) begin
      failures++;
      $display("FAIL midjob_in_run_b got mul=%0d/%0d need 7/9", bus.mul_a, bus.mul_b);
    end
    for (int i = 0; i < N; i++) begin
      op_a[i] = 4'(i + 2);
      op_b[i] = 4'(3);
    end
    vmask = '1;
    apply();
    rst = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== '0 || bus.rsp_valid !== 1'b0 || bus.rsp_id !== '0 || bus.rsp_prod !== '0 ||
        bus.rsp_err !== 1'b0 || bus.mul_a !== '0 || bus.mul_b !== '0 || err_count !== '0) begin
      failures++;
      $display("FAIL midjob_reset got rr=%b rv=%b id=%0d prod=%0d err=%b ma=%0d mb=%0d ec=%0d need all 0",
               bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_prod, bus.rsp_err, bus.mul_a, bus.mul_b, err_count);
    end
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (bus.req_ready !== '0 || bus.rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_held got req_ready=%b rsp_valid=%b need 0 0", bus.req_ready, bus.rsp_valid);
    end
    rst = 1'b0;
    #1;
    last_model = N - 1;
    ec_model   = 0;
    serve(0, 0, 0, '0, "post_reset_priority");
  endtask

  initial begin
    vmask = '0;
    for (int i = 0; i < N; i++) begin
      op_a[i] = '0;
      op_b[i] = '0;
    end
    bus.rsp_ready = 1'b0;
    apply();
    test_reset();
    test_single();
    test_round_robin();
    test_retry_clean();
    test_retry_error();
    test_resp_stall();
    test_random();
    test_reset_midjob();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
`default_nettype wire
